rf80386_ibq: RTL and testbench

//  Parametrised instruction byte queue between the I-cache bundle port and the decoder.

---
 rtl/rf80386_ibq.sv | 155 +++++++++++++++
 tb/tb_rf80386_ibq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rf80386_ibq.sv
// rf80386_ibq: circular instruction byte queue between I-cache fetch bundles and the decoder.
// Optional perf counters (starve_cnt_o, flush_cnt_o) are built when RF80386_IBQ_PERF_EN is defined.
module rf80386_ibq #(
  parameter int BUNDLE_BYTES = 16,
  parameter int DEPTH_BYTES  = 64,
  parameter int PEEK_BYTES   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [31:0]                      flush_ip_i,
  output logic [31:0]                      fetch_ip_o,
  input  logic [BUNDLE_BYTES*8-1:0]        bundle_i,
  input  logic                             bundle_valid_i,
  output logic                             bundle_ready_o,
  output logic [PEEK_BYTES*8-1:0]          peek_o,
  output logic [$clog2(PEEK_BYTES+1)-1:0]  avail_o,
  output logic [31:0]                      head_ip_o,
  input  logic [$clog2(PEEK_BYTES+1)-1:0]  consume_i,
  output logic [$clog2(DEPTH_BYTES+1)-1:0] count_o,
  output logic                             err_o
`ifdef RF80386_IBQ_PERF_EN
  ,
  output logic [31:0]                      starve_cnt_o,
  output logic [31:0]                      flush_cnt_o
`endif
);
  localparam int PTR_W = $clog2(DEPTH_BYTES);
  localparam int OFF_W = $clog2(BUNDLE_BYTES);
  localparam int CNT_W = $clog2(DEPTH_BYTES + 1);
  localparam int AV_W  = $clog2(PEEK_BYTES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] BUNDLE_C = CNT_W'(BUNDLE_BYTES);
  localparam logic [CNT_W-1:0] PEEK_C   = CNT_W'(PEEK_BYTES);
  localparam logic [31:0] RESET_IP   = 32'h000F_0000;
  localparam logic [31:0] ALIGN_MASK = ~32'(BUNDLE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, SKIP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, acc_bytes;
  logic [31:0]      head_ip_q, head_ip_d, fetch_ip_q, fetch_ip_d;
  logic [OFF_W-1:0] skip_q, skip_d, wr_skip;
  logic             err_q, err_d, accept, over;
  logic [AV_W-1:0]  cons_eff;

  // Handshake and clamp decode; ready deliberately ignores this cycle's consume.
  always_comb begin
    avail_o        = (count_q > PEEK_C) ? AV_W'(PEEK_BYTES) : AV_W'(count_q);
    bundle_ready_o = ((DEPTH_C - count_q) >= BUNDLE_C) && !flush_i;
    accept         = bundle_valid_i && bundle_ready_o;
    wr_skip        = (state_q == SKIP) ? skip_q : '0;
    acc_bytes      = BUNDLE_C - CNT_W'(wr_skip);
    over           = consume_i > avail_o;
    cons_eff       = over ? avail_o : consume_i;
  end

  // NOTE: every variable gets its hold value first so no path through the block infers a latch.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    head_ip_d  = head_ip_q;
    fetch_ip_d = fetch_ip_q;
    skip_d     = skip_q;
    err_d      = err_q;
    if (flush_i) begin
      state_d    = SKIP;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      head_ip_d  = flush_ip_i;
      fetch_ip_d = flush_ip_i & ALIGN_MASK;
      skip_d     = flush_ip_i[OFF_W-1:0];
      err_d      = 1'b0;
    end else begin
      head_d    = head_q + PTR_W'(cons_eff);
      head_ip_d = head_ip_q + 32'(cons_eff);
      count_d   = count_q - CNT_W'(cons_eff);
      err_d     = err_q | over;
      if (accept) begin
        tail_d     = tail_q + PTR_W'(acc_bytes);
        count_d    = count_d + acc_bytes;
        fetch_ip_d = fetch_ip_q + 32'(BUNDLE_BYTES);
        skip_d     = '0;
      end
      // SKIP holds until the first post-redirect bundle lands.
      if (state_q != SKIP || accept) state_d = (count_d != '0) ? RUN : IDLE;
    end
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      head_ip_q  <= RESET_IP;
      fetch_ip_q <= RESET_IP;
      skip_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      head_ip_q  <= head_ip_d;
      fetch_ip_q <= fetch_ip_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the byte store has no reset; bytes at or beyond count are masked to 90h on peek.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      for (int k = 0; k < BUNDLE_BYTES; k++) begin
        if (k >= int'(wr_skip))
          mem_q[tail_q + PTR_W'(k) - PTR_W'(wr_skip)] <= bundle_i[k*8 +: 8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PEEK_BYTES; i++)
      peek_o[i*8 +: 8] = (i < int'(avail_o)) ? mem_q[head_q + PTR_W'(i)] : 8'h90;
  end

  assign fetch_ip_o = fetch_ip_q;
  assign head_ip_o  = head_ip_q;
  assign count_o    = count_q;
  assign err_o      = err_q;

`ifdef RF80386_IBQ_PERF_EN
  logic [31:0] starve_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (avail_o == '0 && state_q != SKIP && starve_q != '1) starve_q <= starve_q + 32'd1;
      if (flush_i && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign starve_cnt_o = starve_q;
  assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rf80386_ibq.sv
// Self-checking bench for rf80386_ibq: a byte-queue scoreboard fed on accepted bundles
// and drained on retired bytes, compared against the DUT after every clock.
module tb_rf80386_ibq;
  localparam int BB = 16;
  localparam int DB = 64;
  localparam int PB = 8;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, bundle_valid_i, bundle_ready_o, err_o;
  logic [31:0]     flush_ip_i, fetch_ip_o, head_ip_o;
  logic [BB*8-1:0] bundle_i;
  logic [PB*8-1:0] peek_o;
  logic [3:0]      avail_o, consume_i;
  logic [6:0]      count_o;
`ifdef RF80386_IBQ_PERF_EN
  logic [31:0]     starve_cnt_o, flush_cnt_o;
`endif

  rf80386_ibq #(.BUNDLE_BYTES(BB), .DEPTH_BYTES(DB), .PEEK_BYTES(PB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_ip_i(flush_ip_i),
    .fetch_ip_o(fetch_ip_o), .bundle_i(bundle_i), .bundle_valid_i(bundle_valid_i),
    .bundle_ready_o(bundle_ready_o), .peek_o(peek_o), .avail_o(avail_o),
    .head_ip_o(head_ip_o), .consume_i(consume_i), .count_o(count_o), .err_o(err_o)
`ifdef RF80386_IBQ_PERF_EN
    , .starve_cnt_o(starve_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Scoreboard: expected byte stream plus the architectural side state.
  logic [7:0]  sb[$];
  logic [31:0] m_head_ip, m_fetch_ip;
  logic [3:0]  m_skip;
  bit          m_skip_pend, m_err;
  int unsigned m_flush_cnt, m_starve;

  function automatic int m_avail();
    return (sb.size() > PB) ? PB : sb.size();
  endfunction

  function automatic logic [BB*8-1:0] mk(input logic [7:0] base);
    logic [BB*8-1:0] r;
    for (int k = 0; k < BB; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  function automatic logic [BB*8-1:0] rnd_bundle();
    logic [BB*8-1:0] r;
    for (int k = 0; k < BB / 4; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_head_ip   = 32'h000F_0000;
    m_fetch_ip  = 32'h000F_0000;
    m_skip      = '0;
    m_skip_pend = 1'b0;
    m_err       = 1'b0;
    m_flush_cnt = 0;
    m_starve    = 0;
  endtask

  task automatic check_state(input string tag);
    logic [63:0] ep;
    for (int i = 0; i < PB; i++) ep[i*8 +: 8] = (i < sb.size()) ? sb[i] : 8'h90;
    check({tag, ".count"}, 64'(count_o), 64'(sb.size()));
    check({tag, ".avail"}, 64'(avail_o), 64'(m_avail()));
    check({tag, ".peek"}, peek_o, ep);
    check({tag, ".head_ip"}, 64'(head_ip_o), 64'(m_head_ip));
    check({tag, ".fetch_ip"}, 64'(fetch_ip_o), 64'(m_fetch_ip));
    check({tag, ".err"}, 64'(err_o), 64'(m_err));
`ifdef RF80386_IBQ_PERF_EN
    check({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(m_flush_cnt));
    check({tag, ".starve_cnt"}, 64'(starve_cnt_o), 64'(m_starve));
`endif
  endtask

  task automatic do_reset(input bit with_junk);
    rst_i          = 1'b1;
    flush_i        = with_junk;
    bundle_valid_i = with_junk;
    bundle_i       = mk(8'hA0);
    consume_i      = with_junk ? 4'd3 : 4'd0;
    flush_ip_i     = 32'h0000_1234;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0; flush_i = 1'b0; bundle_valid_i = 1'b0; consume_i = '0;
    model_reset();
    #1;
    check("reset.ready", 64'(bundle_ready_o), 64'd1);
    check_state("reset");
  endtask

  task automatic cycle(input bit v, input logic [BB*8-1:0] b, input int cons,
                       input bit fl, input logic [31:0] fip, input string tag);
    bit acc, rdy;
    int n;
    bundle_valid_i = v; bundle_i = b; consume_i = 4'(cons); flush_i = fl; flush_ip_i = fip;
    #1;
    rdy = !fl && (DB - sb.size() >= BB);
    acc = v && rdy;
    check({tag, ".ready"}, 64'(bundle_ready_o), 64'(rdy));
    if (m_avail() == 0 && !m_skip_pend) m_starve++;
    @(posedge clk_i);
    if (fl) begin
      sb.delete();
      m_err       = 1'b0;
      m_head_ip   = fip;
      m_fetch_ip  = fip & ~32'(BB - 1);
      m_skip      = fip[3:0];
      m_skip_pend = 1'b1;
      m_flush_cnt++;
    end else begin
      n = (cons > m_avail()) ? m_avail() : cons;
      if (cons > m_avail()) m_err = 1'b1;
      repeat (n) void'(sb.pop_front());
      m_head_ip += 32'(n);
      if (acc) begin
        for (int k = (m_skip_pend ? int'(m_skip) : 0); k < BB; k++) sb.push_back(b[k*8 +: 8]);
        m_fetch_ip += 32'(BB);
        m_skip_pend = 1'b0;
        m_skip      = '0;
      end
    end
    #1;
    bundle_valid_i = 1'b0; flush_i = 1'b0; consume_i = '0;
    check_state(tag);
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; flush_ip_i = '0; bundle_i = '0;
    bundle_valid_i = 1'b0; consume_i = '0;
    do_reset(1'b0);

    // First bundle after reset: visible one cycle later.
    cycle(1, mk(8'h00), 0, 0, 0, "t1");
    check("t1.peek07", peek_o, 64'h0706_0504_0302_0100);
    check("t1.fetch", 64'(fetch_ip_o), 64'h000F_0010);

    // Fill to capacity, then consume with a blocked bundle (no bypass), then wrap.
    for (int b = 1; b < 4; b++) cycle(1, mk(8'(b * 16)), 0, 0, 0, "t2fill");
    check("t2.count64", 64'(count_o), 64'd64);
    check("t2.ready0", 64'(bundle_ready_o), 64'd0);
    cycle(1, mk(8'h40), 8, 0, 0, "t2blocked");
    cycle(0, '0, 8, 0, 0, "t2drain");
    cycle(1, mk(8'h50), 0, 0, 0, "t2wrap");
    repeat (8) cycle(0, '0, 8, 0, 0, "t2empty");

    // Unaligned redirect: skip the first 0Bh bytes of the landing bundle.
    cycle(0, '0, 0, 1, 32'h0001_000B, "t3flush");
    check("t3.fetch", 64'(fetch_ip_o), 64'h0001_0000);
    cycle(1, mk(8'h00), 0, 0, 0, "t3");
    check("t3.count5", 64'(count_o), 64'd5);
    check("t3.byte0", 64'(peek_o[7:0]), 64'h0B);
    check("t3.pad", 64'(peek_o[63:40]), 64'h90_9090);

    // Simultaneous accept and consume at count 20.
    cycle(1, mk(8'h20), 0, 0, 0, "t4a");
    cycle(0, '0, 1, 0, 0, "t4b");
    cycle(1, mk(8'h30), 3, 0, 0, "t4");
    check("t4.count33", 64'(count_o), 64'd33);

    // Over-consume clamps and sets the sticky error; flush clears it.
    repeat (3) cycle(0, '0, 8, 0, 0, "t5drain");
    cycle(0, '0, 7, 0, 0, "t5two");
    check("t5.avail2", 64'(avail_o), 64'd2);
    cycle(0, '0, 5, 0, 0, "t5over");
    check("t5.err1", 64'(err_o), 64'd1);
    cycle(0, '0, 3, 0, 0, "t5sticky");
    cycle(0, '0, 0, 1, 32'h0000_5000, "t5flush");
    check("t5.err0", 64'(err_o), 64'd0);

    // Reset wins over flush, bundle and consume in the same cycle.
    do_reset(1'b1);

    // Bundle in the flush cycle is dropped.
    cycle(1, mk(8'h00), 0, 1, 32'h0000_2000, "t6");
    check("t6.count0", 64'(count_o), 64'd0);
`ifdef RF80386_IBQ_PERF_EN
    check("t6.flush_cnt1", 64'(flush_cnt_o), 64'd1);
`endif
    cycle(1, mk(8'h60), 0, 0, 0, "t6land");

    // Address wrap at 2^32.
    cycle(0, '0, 0, 1, 32'hFFFF_FFFA, "wflush");
    cycle(1, rnd_bundle(), 0, 0, 0, "wland");
    cycle(1, rnd_bundle(), 4, 0, 0, "wacc");
    repeat (3) cycle(0, '0, 8, 0, 0, "wdrain");

    // Random traffic with occasional redirects and over-consumes.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_bundle(), int'($urandom_range(0, 10)),
            $urandom_range(0, 24) == 0, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
